ntt_fwd_stream_core: RTL and testbench

// - Forward NTT for Kyber polynomials (N=256, q=3329): loads 32 x 128-bit words, runs 8 Cooley-Tukey

---
 rtl/ntt_fwd_stream_core_if.sv | 30 +++
 rtl/ntt_fwd_stream_core.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_ntt_fwd_stream_core.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_fwd_stream_core_if.sv
`default_nettype none
// ============================================================================
//  Module   : ntt_fwd_stream_core_if
//  Purpose  : Load / result stream bundle for the forward NTT core.
//             master = the side that feeds coefficients and drains results,
//             slave  = the NTT core itself.
//  Revision : 1.0  initial release
// ============================================================================
interface ntt_fwd_stream_core_if;
    logic         start;      // begin a new load (honoured only while idle)
    logic [127:0] data_in;    // 8 coefficients, lane k = [16k+15:16k]
    logic         valid_in;   // input beat valid
    logic         ready_in;   // core accepts input beats (LOAD only)
    logic [127:0] data_out;   // 8 result coefficients, same lane order
    logic         valid_out;  // output beat valid
    logic         out_ready;  // downstream accepts output beat
    logic         busy;       // core not idle
    logic         done;       // one-cycle pulse after the last output beat

    modport master (
        output start, data_in, valid_in, out_ready,
        input  ready_in, data_out, valid_out, busy, done
    );

    modport slave (
        input  start, data_in, valid_in, out_ready,
        output ready_in, data_out, valid_out, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/ntt_fwd_stream_core.sv
`default_nettype none
// ============================================================================
//  Module   : ntt_fwd_stream_core (+ helper ntt_fwd_barrett_reduce)
//  Purpose  : Streaming forward NTT for Kyber (N=256, q=3329). Loads 32 x
//             128-bit words, runs 8 Cooley-Tukey stages (len 128..1) through
//             a 3-deep butterfly pipeline, then streams 32 result words out
//             under valid/ready backpressure. Output is the exact inverse of
//             the unscaled INTT and feeds its load port directly.
//  Option   : `define NTT_IN_REDUCE_EN to reduce every loaded lane mod Q on
//             the write path (any 16-bit input becomes legal).
//  Revision : 1.0  initial release
// ============================================================================

// Barrett reduction of x mod Q, valid for x < 2^24 (covers 12x12-bit
// products and zero-extended 16-bit inputs). With k=24 the quotient
// estimate is short by at most one, so one conditional subtract suffices.
module ntt_fwd_barrett_reduce #(
    parameter int Q = 3329
) (
    input  logic [31:0] x_i,
    output logic [11:0] r_o
);
    localparam logic [47:0] C_M = 48'((48'd1 << 24) / 48'(Q));

    logic [47:0] w_prod;
    logic [23:0] w_quot;
    logic [31:0] w_qq;
    logic [31:0] w_rem;

    // quotient estimate, remainder, single correction step
    always_comb begin
        w_prod = {16'd0, x_i} * C_M;
        w_quot = 24'(w_prod >> 24);
        w_qq   = 32'(w_quot) * 32'(Q);
        w_rem  = x_i - w_qq;
        r_o    = (w_rem >= 32'(Q)) ? 12'(w_rem - 32'(Q)) : 12'(w_rem);
    end
endmodule

module ntt_fwd_stream_core #(
    parameter int Q    = 3329,  // modulus, stored coefficients in [0,Q-1]
    parameter int N    = 256,   // coefficients per polynomial
    parameter int PIPE = 3      // butterfly pipeline depth
) (
    input  logic                 clk,
    input  logic                 rst,
    ntt_fwd_stream_core_if.slave bus
);
    localparam int         WORDS       = N / 8;
    localparam logic [4:0] C_LAST_WORD = 5'(WORDS - 1);
    localparam logic [6:0] C_LAST_PAIR = 7'd127;
    localparam logic [2:0] C_LAST_STG  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ISSUE  = 3'd2,
        S_DRAIN  = 3'd3,
        S_OUTPUT = 3'd4
    } state_t;

    // ---------------- control registers ----------------
    state_t       state_q, state_d;
    logic [4:0]   in_cnt_q, in_cnt_d;     // load word index
    logic [2:0]   stage_q, stage_d;       // NTT stage 0..7
    logic [6:0]   pair_q, pair_d;         // pair index within stage
    logic [11:0]  acc_q, acc_d;           // twiddle for the next pair in group
    logic [4:0]   out_cnt_q, out_cnt_d;   // output word index
    logic         valid_out_q, valid_out_d;
    logic         done_q, done_d;
    logic [127:0] data_out_q, data_out_d;

    // coefficient store
    logic [11:0]  mem_q [N];

    // ---------------- butterfly pipeline ----------------
    // pv_q[0]: operands read, pv_q[1]: t=b*w reduced, pv_q[2]: a'/b' ready
    logic [PIPE-1:0] pv_q;
    logic [7:0]   p1_ia_q, p1_ib_q;
    logic [11:0]  p1_a_q, p1_b_q, p1_w_q;
    logic [7:0]   p2_ia_q, p2_ib_q;
    logic [11:0]  p2_a_q, p2_t_q;
    logic [7:0]   p3_ia_q, p3_ib_q;
    logic [11:0]  p3_a_q, p3_b_q;

    // ---------------- combinational helpers ----------------
    logic [7:0]   w_len;
    logic [6:0]   w_mask, w_k, w_hi;
    logic [7:0]   w_idx_a, w_idx_b;
    logic [11:0]  w_root, w_tw, w_tw_next, w_bf_t;
    logic [31:0]  w_tw_prod, w_bf_prod;
    logic [16:0]  w_sum, w_dif;
    logic [11:0]  w_a_new, w_b_new;
    logic         w_issue, w_load_we;
    logic [11:0]  w_lane [8];
    logic [4:0]   w_word_sel;
    logic [127:0] w_word;

    // per-stage root: inverse of the matching INTT stage root
    always_comb begin
        w_root = 12'd1;
        case (stage_q)
            3'd0:    w_root = 12'd3061;
            3'd1:    w_root = 12'd1915;
            3'd2:    w_root = 12'd1996;
            3'd3:    w_root = 12'd2532;
            3'd4:    w_root = 12'd2699;
            3'd5:    w_root = 12'd749;
            3'd6:    w_root = 12'd1729;
            default: w_root = 12'd3328;
        endcase
    end

    // pair addresses: split pair index into group (high bits) and offset k,
    // then j = group*2L + k and partner j+L; twiddle restarts at 1 per group
    always_comb begin
        w_len     = 8'd128 >> stage_q;
        w_mask    = 7'(w_len - 8'd1);
        w_k       = pair_q & w_mask;
        w_hi      = pair_q & ~w_mask;
        w_idx_a   = {w_hi, 1'b0} | {1'b0, w_k};
        w_idx_b   = w_idx_a | w_len;
        w_tw      = (w_k == 7'd0) ? 12'd1 : acc_q;
        w_tw_prod = 32'(w_tw) * 32'(w_root);
        w_bf_prod = 32'(p1_b_q) * 32'(p1_w_q);
    end

    ntt_fwd_barrett_reduce #(.Q(Q)) u_tw_red (
        .x_i (w_tw_prod),
        .r_o (w_tw_next)
    );

    ntt_fwd_barrett_reduce #(.Q(Q)) u_bf_red (
        .x_i (w_bf_prod),
        .r_o (w_bf_t)
    );

    // modular add/sub of the butterfly on 17-bit intermediates
    always_comb begin
        w_sum   = {5'd0, p2_a_q} + {5'd0, p2_t_q};
        w_dif   = {5'd0, p2_a_q} + 17'(Q) - {5'd0, p2_t_q};
        w_a_new = (w_sum >= 17'(Q)) ? 12'(w_sum - 17'(Q)) : 12'(w_sum);
        w_b_new = (w_dif >= 17'(Q)) ? 12'(w_dif - 17'(Q)) : 12'(w_dif);
    end

    // load-path lane conditioning
`ifdef NTT_IN_REDUCE_EN
    for (genvar gk = 0; gk < 8; gk++) begin : g_in_reduce
        ntt_fwd_barrett_reduce #(.Q(Q)) u_in_red (
            .x_i ({16'd0, bus.data_in[16*gk +: 16]}),
            .r_o (w_lane[gk])
        );
    end
`else
    // caller guarantees lanes < Q, so the upper lane bits are zero
    for (genvar gk = 0; gk < 8; gk++) begin : g_in_raw
        assign w_lane[gk] = 12'(bus.data_in[16*gk +: 16]);
    end
`endif

    // gather the next output word: word 0 when entering OUTPUT, else k+1
    always_comb begin
        w_word     = '0;
        w_word_sel = (state_q == S_OUTPUT) ? (out_cnt_q + 5'd1) : 5'd0;
        for (int k = 0; k < 8; k++) begin
            w_word[16*k +: 16] = {4'd0, mem_q[{w_word_sel, 3'(k)}]};
        end
    end

    // FSM next state and register updates
    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        stage_d     = stage_q;
        pair_d      = pair_q;
        acc_d       = acc_q;
        out_cnt_d   = out_cnt_q;
        valid_out_d = valid_out_q;
        done_d      = 1'b0;
        data_out_d  = data_out_q;
        w_issue     = 1'b0;
        w_load_we   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_LOAD;
                    in_cnt_d = 5'd0;
                end
            end
            S_LOAD: begin
                if (bus.valid_in) begin
                    w_load_we = 1'b1;
                    in_cnt_d  = in_cnt_q + 5'd1;
                    if (in_cnt_q == C_LAST_WORD) begin
                        state_d = S_ISSUE;
                        stage_d = 3'd0;
                        pair_d  = 7'd0;
                    end
                end
            end
            S_ISSUE: begin
                // pairs of one stage are disjoint: never stall mid-stage
                w_issue = 1'b1;
                acc_d   = w_tw_next;
                pair_d  = pair_q + 7'd1;
                if (pair_q == C_LAST_PAIR) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // next stage must see every write of this one
                if (pv_q == '0) begin
                    if (stage_q == C_LAST_STG) begin
                        state_d     = S_OUTPUT;
                        out_cnt_d   = 5'd0;
                        valid_out_d = 1'b1;
                        data_out_d  = w_word;
                    end else begin
                        state_d = S_ISSUE;
                        stage_d = stage_q + 3'd1;
                    end
                end
            end
            S_OUTPUT: begin
                if (valid_out_q && bus.out_ready) begin
                    if (out_cnt_q == C_LAST_WORD) begin
                        state_d     = S_IDLE;
                        valid_out_d = 1'b0;
                        done_d      = 1'b1;
                        data_out_d  = '0;
                    end else begin
                        out_cnt_d  = out_cnt_q + 5'd1;
                        data_out_d = w_word;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // control state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_cnt_q    <= 5'd0;
            stage_q     <= 3'd0;
            pair_q      <= 7'd0;
            acc_q       <= 12'd1;
            out_cnt_q   <= 5'd0;
            valid_out_q <= 1'b0;
            done_q      <= 1'b0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            stage_q     <= stage_d;
            pair_q      <= pair_d;
            acc_q       <= acc_d;
            out_cnt_q   <= out_cnt_d;
            valid_out_q <= valid_out_d;
            done_q      <= done_d;
            data_out_q  <= data_out_d;
        end
    end

    // butterfly pipeline: read -> multiply+reduce -> add/sub
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_q    <= '0;
            p1_ia_q <= '0;
            p1_ib_q <= '0;
            p1_a_q  <= '0;
            p1_b_q  <= '0;
            p1_w_q  <= '0;
            p2_ia_q <= '0;
            p2_ib_q <= '0;
            p2_a_q  <= '0;
            p2_t_q  <= '0;
            p3_ia_q <= '0;
            p3_ib_q <= '0;
            p3_a_q  <= '0;
            p3_b_q  <= '0;
        end else begin
            pv_q <= {pv_q[PIPE-2:0], w_issue};
            if (w_issue) begin
                p1_ia_q <= w_idx_a;
                p1_ib_q <= w_idx_b;
                p1_a_q  <= mem_q[w_idx_a];
                p1_b_q  <= mem_q[w_idx_b];
                p1_w_q  <= w_tw;
            end
            if (pv_q[0]) begin
                p2_ia_q <= p1_ia_q;
                p2_ib_q <= p1_ib_q;
                p2_a_q  <= p1_a_q;
                p2_t_q  <= w_bf_t;
            end
            if (pv_q[1]) begin
                p3_ia_q <= p2_ia_q;
                p3_ib_q <= p2_ib_q;
                p3_a_q  <= w_a_new;
                p3_b_q  <= w_b_new;
            end
        end
    end

    // coefficient store: 8-lane load writes, 2-lane butterfly writeback
    always_ff @(posedge clk) begin
        if (w_load_we) begin
            for (int k = 0; k < 8; k++) begin
                mem_q[{in_cnt_q, 3'(k)}] <= w_lane[k];
            end
        end
        if (pv_q[PIPE-1]) begin
            mem_q[p3_ia_q] <= p3_a_q;
            mem_q[p3_ib_q] <= p3_b_q;
        end
    end

    assign bus.ready_in  = (state_q == S_LOAD);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.valid_out = valid_out_q;
    assign bus.data_out  = data_out_q;
    assign bus.done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ntt_fwd_stream_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ntt_fwd_stream_core
//  Purpose  : Directed self-checking bench for ntt_fwd_stream_core.
//             Delta / zero vectors carry hand-derived results; random vectors
//             are checked against a plain modular-arithmetic reference NTT.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ntt_fwd_stream_core;
    localparam int Q = 3329;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ntt_fwd_stream_core_if bus ();

    ntt_fwd_stream_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int in_c  [256];
    int exp_c [256];

    task automatic check_vec(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pack_in(input int w);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[16*k +: 16] = 16'(in_c[8*w+k]);
        return r;
    endfunction

    function automatic logic [127:0] pack_exp(input int w);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[16*k +: 16] = 16'(exp_c[8*w+k]);
        return r;
    endfunction

    // straightforward forward NTT written from the butterfly definition
    task automatic model_fwd();
        int a [256];
        int root [8];
        int len, w, t, x;
        root = '{3061, 1915, 1996, 2532, 2699, 749, 1729, 3328};
        for (int i = 0; i < 256; i++) a[i] = in_c[i];
        for (int s = 0; s < 8; s++) begin
            len = 128 >> s;
            for (int st = 0; st < 256; st += 2*len) begin
                w = 1;
                for (int j = st; j < st + len; j++) begin
                    t = (a[j+len] * w) % Q;
                    x = a[j];
                    a[j]     = (x + t) % Q;
                    a[j+len] = (x + Q - t) % Q;
                    w = (w * root[s]) % Q;
                end
            end
        end
        for (int i = 0; i < 256; i++) exp_c[i] = a[i];
    endtask

    task automatic clear_in();
        for (int i = 0; i < 256; i++) in_c[i] = 0;
    endtask

    task automatic random_in();
        for (int i = 0; i < 256; i++) in_c[i] = int'($urandom_range(0, Q-1));
    endtask

    task automatic load_poly(input string tag);
        int beats, guard;
        bit acc;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_vec({tag, "_busy_load"}, 128'(bus.busy), 128'(1));
        beats = 0;
        guard = 0;
        while (beats < 32 && guard < 100) begin
            bus.data_in  = pack_in(beats);
            bus.valid_in = 1'b1;
            acc = bus.ready_in;
            @(negedge clk);
            if (acc) beats++;
            guard++;
        end
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        check_vec({tag, "_load_beats"}, 128'(beats), 128'(32));
        check_vec({tag, "_ready_low"}, 128'(bus.ready_in), 128'(0));
    endtask

    task automatic collect(input string tag, input bit bp);
        int guard, w, cyc;
        bit hs;
        guard = 0;
        while (!bus.valid_out && guard < 1200) begin
            @(negedge clk);
            guard++;
        end
        check_vec({tag, "_latency"}, 128'(guard < 1200), 128'(1));
        w = 0;
        cyc = 0;
        guard = 0;
        while (w < 32 && guard < 300) begin
            bus.out_ready = bp ? (cyc % 3 == 0) : 1'b1;
            if (bus.valid_out)
                check_vec($sformatf("%s_w%0d", tag, w), bus.data_out, pack_exp(w));
            hs = bus.valid_out && bus.out_ready;
            @(negedge clk);
            if (hs) w++;
            cyc++;
            guard++;
        end
        bus.out_ready = 1'b0;
        check_vec({tag, "_words"}, 128'(w), 128'(32));
        check_vec({tag, "_done_pulse"}, 128'(bus.done), 128'(1));
        check_vec({tag, "_valid_drop"}, 128'(bus.valid_out), 128'(0));
        check_vec({tag, "_idle"}, 128'(bus.busy), 128'(0));
        @(negedge clk);
        check_vec({tag, "_done_clear"}, 128'(bus.done), 128'(0));
    endtask

    task automatic run_ntt(input string tag, input bit bp, input bit junk);
        load_poly(tag);
        if (junk) begin
            // start and input beats while computing must be ignored
            bus.start    = 1'b1;
            bus.valid_in = 1'b1;
            bus.data_in  = {128{1'b1}};
            repeat (5) @(negedge clk);
            bus.start    = 1'b0;
            bus.valid_in = 1'b0;
            bus.data_in  = '0;
        end
        collect(tag, bp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.data_in   = '0;
        bus.valid_in  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_vec("rst_busy",      128'(bus.busy),      128'(0));
        check_vec("rst_ready_in",  128'(bus.ready_in),  128'(0));
        check_vec("rst_valid_out", 128'(bus.valid_out), 128'(0));
        check_vec("rst_done",      128'(bus.done),      128'(0));
        check_vec("rst_data_out",  bus.data_out,        128'(0));
        rst = 1'b0;

        // all zero -> all zero
        clear_in();
        for (int i = 0; i < 256; i++) exp_c[i] = 0;
        run_ntt("zero", 1'b0, 1'b0);

        // delta at 0 -> every output 1
        clear_in();
        in_c[0] = 1;
        for (int i = 0; i < 256; i++) exp_c[i] = 1;
        run_ntt("delta0", 1'b0, 1'b0);

        // delta at 128 -> lower half 1, upper half Q-1
        clear_in();
        in_c[128] = 1;
        for (int i = 0; i < 256; i++) exp_c[i] = (i < 128) ? 1 : Q - 1;
        run_ntt("delta128", 1'b0, 1'b0);

        // delta at 1 -> even 1, odd Q-1
        clear_in();
        in_c[1] = 1;
        for (int i = 0; i < 256; i++) exp_c[i] = (i % 2 == 0) ? 1 : Q - 1;
        run_ntt("delta1", 1'b0, 1'b0);

        // delta at 129 uses twiddle 3061 in stage 0: a'=3061, b'=268
        clear_in();
        in_c[129] = 1;
        for (int i = 0; i < 256; i++)
            exp_c[i] = (i < 128) ? ((i % 2 == 0) ? 3061 : 268)
                                 : ((i % 2 == 0) ? 268 : 3061);
        run_ntt("delta129", 1'b0, 1'b0);

        // random vector with stray start/valid_in during compute
        random_in();
        model_fwd();
        run_ntt("rand_a", 1'b0, 1'b1);

        // same vector under 1-of-3 backpressure
        run_ntt("rand_bp", 1'b1, 1'b0);

        // reset in the middle of compute
        load_poly("rst_mid");
        repeat (500) @(negedge clk);
        rst = 1'b1;
        #1;
        check_vec("rst_mid_busy",  128'(bus.busy),      128'(0));
        check_vec("rst_mid_valid", 128'(bus.valid_out), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        check_vec("rst_mid_ready", 128'(bus.ready_in),  128'(0));

        random_in();
        model_fwd();
        run_ntt("rand_after_rst", 1'b0, 1'b0);

`ifdef NTT_IN_REDUCE_EN
        // out-of-range lanes must behave as their residues
        random_in();
        in_c[0] = 3329 % Q;
        in_c[1] = 6658 % Q;
        in_c[2] = 65535 % Q;
        model_fwd();
        in_c[0] = 3329;
        in_c[1] = 6658;
        in_c[2] = 65535;
        run_ntt("in_reduce", 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
